// File: rtl/poly_voice_synth.sv
// rtl/poly_voice_synth.sv - polyphonic note allocator, per-voice linear envelope and time-multiplexed mixer
module poly_voice_synth #(
    parameter int N_VOICES     = 8,
    parameter int PHASE_BITS   = 32,
    parameter int SAMPLE_WIDTH = 24,
    parameter int ENV_BITS     = 8,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 1
) (
    input  logic                    clk_in,
    input  logic                    n_rst_in,
    input  logic                    event_valid_in,
    output logic                    event_ready_out,
    input  logic                    event_on_in,
    input  logic [6:0]              note_in,
    input  logic [6:0]              velocity_in,
    input  logic [PHASE_BITS-1:0]   phase_incr_in,
    input  logic [1:0]              wave_type_in,
    input  logic                    sample_tick_in,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    valid_out,
    output logic [N_VOICES-1:0]     active_voices_out,
    output logic                    overrun_out
);
    localparam int SW     = SAMPLE_WIDTH;
    localparam int VIDX_W = $clog2(N_VOICES);
    localparam int ACC_W  = SW + VIDX_W;
    localparam int PROD_W = SW + ENV_BITS + 1;
    localparam logic [ENV_BITS:0]     ATK_INC  = (ENV_BITS+1)'(ATTACK_STEP);
    localparam logic [ENV_BITS-1:0]   REL_DEC  = ENV_BITS'(RELEASE_STEP);
    localparam logic signed [SW-1:0]  WAVE_MAX = {1'b0, {(SW-1){1'b1}}};

    typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_state_t;
    typedef enum logic [2:0] {S_WAIT, S_MIX, S_DRAIN, S_LOAD, S_DONE} mix_state_t;

    voice_state_t          v_state  [N_VOICES];
    logic [6:0]            v_note   [N_VOICES];
    logic [ENV_BITS-1:0]   v_target [N_VOICES];
    logic [ENV_BITS-1:0]   v_env    [N_VOICES];
    logic [PHASE_BITS-1:0] v_phase  [N_VOICES];
    logic [PHASE_BITS-1:0] v_incr   [N_VOICES];
    logic [1:0]            v_wave   [N_VOICES];

    mix_state_t        state, state_nxt;
    logic [VIDX_W-1:0] mix_idx;
    logic [VIDX_W-1:0] steal_ptr;

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state   <= S_WAIT;
            mix_idx <= '0;
        end else begin
            state   <= state_nxt;
            mix_idx <= (state == S_MIX) ? mix_idx + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt       = state;
        event_ready_out = 1'b0;
        valid_out       = 1'b0;
        case (state)
            S_WAIT: begin
                event_ready_out = 1'b1;
                if (sample_tick_in) state_nxt = S_MIX;
            end
            S_MIX:   if (mix_idx == VIDX_W'(N_VOICES - 1)) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_DONE;
            S_DONE: begin
                valid_out = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    logic              accept, note_on;
    logic              match_hit, idle_hit;
    logic [VIDX_W-1:0] match_idx, idle_idx, alloc_idx;

    assign accept  = event_valid_in && event_ready_out;
    assign note_on = event_on_in && (velocity_in != 7'd0);

    // Descending scan leaves the lowest matching index in each result.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        idle_hit  = 1'b0;
        idle_idx  = '0;
        for (int i = N_VOICES - 1; i >= 0; i--) begin
            if (v_state[i] != V_IDLE && v_note[i] == note_in) begin
                match_hit = 1'b1;
                match_idx = VIDX_W'(i);
            end
            if (v_state[i] == V_IDLE) begin
                idle_hit = 1'b1;
                idle_idx = VIDX_W'(i);
            end
        end
        alloc_idx = idle_hit ? idle_idx : steal_ptr;
    end

    voice_state_t          cur_state, upd_state;
    logic [ENV_BITS-1:0]   cur_env, upd_env;
    logic [ENV_BITS:0]     env_sum;
    logic [SW-1:0]         p;
    logic [SW-2:0]         fold;
    logic signed [SW-1:0]  wave_val, voice_out;
    logic signed [PROD_W-1:0] wave_ext, env_ext, prod;

    // The mix of a voice uses the envelope after this tick's step and the phase before it.
    always_comb begin
        cur_state = v_state[mix_idx];
        cur_env   = v_env[mix_idx];
        upd_state = cur_state;
        upd_env   = cur_env;
        env_sum   = {1'b0, cur_env} + ATK_INC;
        case (cur_state)
            V_ATTACK: begin
                if (env_sum >= {1'b0, v_target[mix_idx]}) begin
                    upd_env   = v_target[mix_idx];
                    upd_state = V_SUSTAIN;
                end else begin
                    upd_env = env_sum[ENV_BITS-1:0];
                end
            end
            V_RELEASE: begin
                if (cur_env <= REL_DEC) begin
                    upd_env   = '0;
                    upd_state = V_IDLE;
                end else begin
                    upd_env = cur_env - REL_DEC;
                end
            end
            V_SUSTAIN: upd_env = cur_env;
            default:   upd_env = '0;
        endcase

        p    = v_phase[mix_idx][PHASE_BITS-1 -: SW];
        fold = p[SW-1] ? ~p[SW-2:0] : p[SW-2:0];
        case (v_wave[mix_idx])
            2'd0:    wave_val = {~p[SW-1], p[SW-2:0]};
            2'd1:    wave_val = p[SW-1] ? -WAVE_MAX : WAVE_MAX;
            2'd2:    wave_val = {~fold[SW-2], fold[SW-3:0], 1'b0};
            default: wave_val = '0;
        endcase

        wave_ext  = PROD_W'(wave_val);
        env_ext   = PROD_W'({1'b0, upd_env});
        prod      = wave_ext * env_ext;
        voice_out = (cur_state == V_IDLE) ? '0 : SW'(prod >>> ENV_BITS);
    end

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            for (int i = 0; i < N_VOICES; i++) begin
                v_state[i]  <= V_IDLE;
                v_note[i]   <= '0;
                v_target[i] <= '0;
                v_env[i]    <= '0;
                v_phase[i]  <= '0;
                v_incr[i]   <= '0;
                v_wave[i]   <= '0;
            end
            steal_ptr <= '0;
        end else if (accept) begin
            if (note_on && match_hit) begin
                v_state[match_idx]  <= V_ATTACK;
                v_target[match_idx] <= ENV_BITS'({velocity_in, 1'b0});
                v_incr[match_idx]   <= phase_incr_in;
                v_wave[match_idx]   <= wave_type_in;
            end else if (note_on) begin
                v_state[alloc_idx]  <= V_ATTACK;
                v_note[alloc_idx]   <= note_in;
                v_target[alloc_idx] <= ENV_BITS'({velocity_in, 1'b0});
                v_env[alloc_idx]    <= '0;
                v_phase[alloc_idx]  <= '0;
                v_incr[alloc_idx]   <= phase_incr_in;
                v_wave[alloc_idx]   <= wave_type_in;
                if (!idle_hit) steal_ptr <= steal_ptr + 1'b1;
            end else begin
                for (int i = 0; i < N_VOICES; i++) begin
                    if (v_note[i] == note_in && (v_state[i] == V_ATTACK || v_state[i] == V_SUSTAIN))
                        v_state[i] <= V_RELEASE;
                end
            end
        end else if (state == S_MIX) begin
            v_state[mix_idx] <= upd_state;
            v_env[mix_idx]   <= upd_env;
            if (cur_state != V_IDLE) v_phase[mix_idx] <= v_phase[mix_idx] + v_incr[mix_idx];
        end
    end

    logic signed [SW-1:0]    mul_q;
    logic                    mul_vld;
    logic signed [ACC_W-1:0] acc;

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            mul_q       <= '0;
            mul_vld     <= 1'b0;
            acc         <= '0;
            sample_out  <= '0;
            overrun_out <= 1'b0;
        end else begin
            mul_vld <= (state == S_MIX);
            if (state == S_MIX) mul_q <= voice_out;
            if (state == S_WAIT && sample_tick_in) acc <= '0;
            else if (mul_vld) acc <= acc + ACC_W'(mul_q);
            if (state == S_LOAD) sample_out <= SW'(acc >>> VIDX_W);
            overrun_out <= sample_tick_in && (state != S_WAIT);
        end
    end

    always_comb begin
        active_voices_out = '0;
        for (int i = 0; i < N_VOICES; i++) active_voices_out[i] = (v_state[i] != V_IDLE);
    end
endmodule

// File: tb/tb_poly_voice_synth.sv
// tb/tb_poly_voice_synth.sv - self-checking bench for poly_voice_synth with a behavioural voice model
module tb_poly_voice_synth;
    localparam int NV = 4;

    logic        clk_in, n_rst_in;
    logic        event_valid_in, event_ready_out, event_on_in;
    logic [6:0]  note_in, velocity_in;
    logic [31:0] phase_incr_in;
    logic [1:0]  wave_type_in;
    logic        sample_tick_in;
    logic [23:0] sample_out;
    logic        valid_out, overrun_out;
    logic [NV-1:0] active_voices_out;

    poly_voice_synth #(.N_VOICES(NV)) dut (
        .clk_in(clk_in), .n_rst_in(n_rst_in),
        .event_valid_in(event_valid_in), .event_ready_out(event_ready_out),
        .event_on_in(event_on_in), .note_in(note_in), .velocity_in(velocity_in),
        .phase_incr_in(phase_incr_in), .wave_type_in(wave_type_in),
        .sample_tick_in(sample_tick_in), .sample_out(sample_out), .valid_out(valid_out),
        .active_voices_out(active_voices_out), .overrun_out(overrun_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int accepts = 0;

    always @(posedge clk_in) if (n_rst_in && event_valid_in && event_ready_out) accepts++;

    // Model voice states: 0 idle, 1 attack, 2 sustain, 3 release.
    int     m_state [NV];
    int     m_note [NV], m_target [NV], m_env [NV], m_wave [NV];
    longint m_phase [NV], m_incr [NV];
    int     m_steal;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NV; i++) begin
            m_state[i] = 0; m_note[i] = 0; m_target[i] = 0; m_env[i] = 0;
            m_wave[i] = 0; m_phase[i] = 0; m_incr[i] = 0;
        end
        m_steal = 0;
    endfunction

    function automatic void m_event(input bit on, input int note, input int vel, input int wave, input longint incr);
        int v;
        v = -1;
        if (on && vel != 0) begin
            for (int i = 0; i < NV; i++) if (m_state[i] != 0 && m_note[i] == note) v = i;
            if (v >= 0) begin
                m_state[v] = 1; m_target[v] = vel * 2; m_incr[v] = incr; m_wave[v] = wave;
            end else begin
                for (int i = NV - 1; i >= 0; i--) if (m_state[i] == 0) v = i;
                if (v < 0) begin
                    v = m_steal;
                    m_steal = (m_steal + 1) % NV;
                end
                m_state[v] = 1; m_note[v] = note; m_target[v] = vel * 2; m_env[v] = 0;
                m_phase[v] = 0; m_incr[v] = incr; m_wave[v] = wave;
            end
        end else begin
            for (int i = 0; i < NV; i++)
                if (m_note[i] == note && (m_state[i] == 1 || m_state[i] == 2)) m_state[i] = 3;
        end
    endfunction

    function automatic longint m_wave_val(input int wave, input longint phase);
        longint p, t;
        p = phase >> 8;
        case (wave)
            0: return p - 64'sd8388608;
            1: return (p >= 8388608) ? -64'sd8388607 : 64'sd8388607;
            2: begin
                t = (p < 8388608) ? p : 16777215 - p;
                return 2 * t - 64'sd8388608;
            end
            default: return 0;
        endcase
    endfunction

    function automatic longint m_mix();
        longint acc, w;
        acc = 0;
        for (int i = 0; i < NV; i++) begin
            if (m_state[i] != 0) begin
                w = m_wave_val(m_wave[i], m_phase[i]);
                if (m_state[i] == 1) begin
                    m_env[i] = m_env[i] + 4;
                    if (m_env[i] >= m_target[i]) begin m_env[i] = m_target[i]; m_state[i] = 2; end
                end else if (m_state[i] == 3) begin
                    m_env[i] = m_env[i] - 1;
                    if (m_env[i] <= 0) begin m_env[i] = 0; m_state[i] = 0; end
                end
                m_phase[i] = (m_phase[i] + m_incr[i]) & 64'hFFFF_FFFF;
                acc += (w * longint'(m_env[i])) >>> 8;
            end
        end
        return acc >>> 2;
    endfunction

    function automatic longint m_active();
        longint a;
        a = 0;
        for (int i = 0; i < NV; i++) if (m_state[i] != 0) a |= (64'd1 << i);
        return a;
    endfunction

    task automatic reset_dut();
        n_rst_in = 1'b0;
        event_valid_in = 0; event_on_in = 0; note_in = 0; velocity_in = 0;
        phase_incr_in = 0; wave_type_in = 0; sample_tick_in = 0;
        repeat (2) @(negedge clk_in);
        n_rst_in = 1'b1;
        m_reset();
        @(negedge clk_in);
    endtask

    task automatic send_event(input bit on, input int note, input int vel, input int wave, input logic [31:0] incr);
        int waited;
        waited = 0;
        event_valid_in = 1; event_on_in = on; note_in = 7'(note); velocity_in = 7'(vel);
        wave_type_in = 2'(wave); phase_incr_in = incr;
        while (!event_ready_out && waited < 20) begin @(negedge clk_in); waited++; end
        check("event_ready", event_ready_out, 1);
        @(negedge clk_in);
        event_valid_in = 0;
        m_event(on, note, vel, wave, longint'(incr));
    endtask

    task automatic do_tick(input string tag, output longint smp);
        longint exp_s;
        int lat;
        exp_s = m_mix();
        sample_tick_in = 1; lat = -1; smp = 0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk_in);
            sample_tick_in = 0; event_valid_in = 0;
            if (valid_out) begin lat = c; smp = longint'($signed(sample_out)); end
        end
        @(negedge clk_in);
        check({tag, "_latency"}, lat, 7);
        check({tag, "_sample"}, smp, exp_s);
        check({tag, "_active"}, active_voices_out, m_active());
    endtask

    typedef struct {
        bit          on;
        int          note;
        int          vel;
        int          wave;
        logic [31:0] incr;
        logic [3:0]  exp_active;
    } vec_t;

    vec_t vecs [10];

    initial begin
        longint smp, exp_s;
        int rel, low, ov, vc, acc0;

        vecs[0] = '{1, 60, 100, 0, 32'h0100_0000, 4'b0001};
        vecs[1] = '{1, 62,  90, 1, 32'h0200_0000, 4'b0011};
        vecs[2] = '{1, 64,  80, 2, 32'h0300_0000, 4'b0111};
        vecs[3] = '{1, 65,  70, 0, 32'h0080_0000, 4'b1111};
        vecs[4] = '{1, 67, 127, 0, 32'h1000_0000, 4'b1111};
        vecs[5] = '{0, 61,   0, 0, 32'h0,         4'b1111};
        vecs[6] = '{1, 62, 127, 1, 32'h0400_0000, 4'b1111};
        vecs[7] = '{0, 67,   0, 0, 32'h0,         4'b1111};
        vecs[8] = '{1, 69,  60, 2, 32'h0700_0000, 4'b1111};
        vecs[9] = '{0, 62,   0, 0, 32'h0,         4'b1111};

        reset_dut();
        check("rst_sample", sample_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_overrun", overrun_out, 0);
        check("rst_active", active_voices_out, 0);
        check("rst_ready", event_ready_out, 1);

        send_event(1, 60, 127, 0, 32'h1000_0000);
        for (int t = 0; t < 66; t++) begin
            do_tick("single", smp);
            if (t == 0) check("single_first_env4", smp, -32768);
            if (t == 1) check("single_second_env8", smp, -57344);
            repeat (500) @(negedge clk_in);
        end

        reset_dut();
        for (int k = 0; k < 10; k++) begin
            send_event(vecs[k].on, vecs[k].note, vecs[k].vel, vecs[k].wave, vecs[k].incr);
            do_tick("alloc", smp);
            check($sformatf("alloc_vec%0d_active", k), active_voices_out, vecs[k].exp_active);
        end

        reset_dut();
        send_event(1, 60, 10, 0, 32'h0400_0000);
        repeat (6) do_tick("retrig_pre", smp);
        send_event(1, 60, 127, 1, 32'h0800_0000);
        do_tick("retrig", smp);
        check("retrig_single_voice", active_voices_out, 4'b0001);
        send_event(0, 61, 0, 0, 0);
        do_tick("noteoff_nomatch", smp);
        send_event(0, 60, 0, 0, 0);
        rel = 0;
        while (active_voices_out != 0 && rel < 300) begin
            do_tick("release", smp);
            rel++;
        end
        check("release_ticks", rel, 28);

        send_event(1, 62, 80, 2, 32'h0123_4567);
        repeat (3) do_tick("vel0_pre", smp);
        send_event(1, 62, 0, 2, 32'h0123_4567);
        repeat (2) do_tick("vel0", smp);

        acc0 = accepts;
        sample_tick_in = 1;
        @(negedge clk_in);
        sample_tick_in = 0;
        exp_s = m_mix();
        event_valid_in = 1; event_on_in = 1; note_in = 7'd72; velocity_in = 7'd50;
        wave_type_in = 2'd1; phase_incr_in = 32'h0200_0000;
        check("hs_ready_low", event_ready_out, 0);
        low = 0; smp = 0;
        for (int c = 0; c < 20 && !event_ready_out; c++) begin
            if (valid_out) smp = longint'($signed(sample_out));
            low++;
            @(negedge clk_in);
        end
        check("hs_ready_low_cycles", low, 7);
        check("hs_sample", smp, exp_s);
        @(negedge clk_in);
        event_valid_in = 0;
        m_event(1, 72, 50, 1, 64'h0200_0000);
        repeat (3) @(negedge clk_in);
        check("hs_accepted_once", accepts - acc0, 1);
        do_tick("hs_after", smp);

        exp_s = m_mix();
        ov = 0; vc = 0; smp = 0;
        sample_tick_in = 1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_in);
            sample_tick_in = (c == 2);
            if (overrun_out) ov++;
            if (valid_out) begin vc++; smp = longint'($signed(sample_out)); end
        end
        check("overrun_pulses", ov, 1);
        check("overrun_valid_count", vc, 1);
        check("overrun_sample", smp, exp_s);

        sample_tick_in = 1;
        @(negedge clk_in);
        sample_tick_in = 0;
        repeat (2) @(negedge clk_in);
        n_rst_in = 0;
        #1;
        check("midrst_sample", sample_out, 0);
        check("midrst_valid", valid_out, 0);
        check("midrst_active", active_voices_out, 0);
        check("midrst_overrun", overrun_out, 0);
        @(negedge clk_in);
        n_rst_in = 1;
        m_reset();
        #1;
        check("midrst_ready", event_ready_out, 1);
        vc = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (valid_out) vc++;
        end
        check("midrst_no_valid", vc, 0);

        event_valid_in = 1; event_on_in = 1; note_in = 7'd70; velocity_in = 7'd127;
        wave_type_in = 2'd0; phase_incr_in = 32'h1000_0000;
        m_event(1, 70, 127, 0, 64'h1000_0000);
        do_tick("simul", smp);
        check("simul_env4", smp, -32768);

        for (int it = 0; it < 250; it++) begin
            int nev;
            nev = $urandom_range(0, 2);
            for (int e = 0; e < nev; e++) begin
                bit on;
                int vel;
                on  = ($urandom_range(0, 9) < 7);
                vel = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127));
                send_event(on, 60 + int'($urandom_range(0, 5)), vel, int'($urandom_range(0, 3)), $urandom);
            end
            do_tick("rand", smp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
